// File: rtl/bullet_pool_if.sv
// Pixel stream from bullet_pool to the VGA plotter.
// Fields are held until plot_en && plot_ready.
interface bullet_pool_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7
);
  logic [X_W-1:0] plot_x;
  logic [Y_W-1:0] plot_y;
  logic [2:0]     plot_colour;
  logic           plot_en;
  logic           plot_ready;

  modport master (
    output plot_x,
    output plot_y,
    output plot_colour,
    output plot_en,
    input  plot_ready
  );

  modport slave (
    input  plot_x,
    input  plot_y,
    input  plot_colour,
    input  plot_en,
    output plot_ready
  );
endinterface

// File: rtl/bullet_pool.sv
// Player bullet manager: spawns, moves and retires bullet slots,
// serialising every erase/draw pixel onto the plotter handshake.
module bullet_pool #(
  parameter int NUM_BULLETS = 4,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int START_Y     = 105,
  parameter int STEP        = 5,
  parameter int COOLDOWN    = 3,
  localparam int IDX_W =
    (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fire,
  input  logic [X_W-1:0]           xin,
  input  logic                     frame_tick,
  input  logic                     hit_valid,
  input  logic [IDX_W-1:0]         hit_idx,
  bullet_pool_if.master            plot,
  output logic [NUM_BULLETS-1:0]   active_mask,
  output logic [NUM_BULLETS*X_W-1:0] bullet_x,
  output logic [NUM_BULLETS*Y_W-1:0] bullet_y,
  output logic                     busy,
  output logic                     tick_missed
);
  localparam int CW =
    (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int AW = 2 ** IDX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_ERASE,
    S_DRAW,
    S_NEXT
  } state_t;

  state_t                 r_state;
  state_t                 w_nstate;
  logic [IDX_W-1:0]       r_idx;
  logic [NUM_BULLETS-1:0] r_active;
  logic [NUM_BULLETS-1:0] r_kill;
  logic [X_W-1:0]         r_x [NUM_BULLETS];
  logic [Y_W-1:0]         r_y [NUM_BULLETS];
  logic                   r_pend;
  logic [CW-1:0]          r_cool;

  logic [IDX_W-1:0] w_free;
  logic             w_free_ok;
  logic             w_fire;
  logic             w_spawn;
  logic             w_accept;
  logic             w_cur_act;
  logic             w_kill_now;
  logic             w_retire;
  logic             w_last;
  logic             w_hit_ok;
  logic [AW-1:0]    w_act_ext;
  logic [X_W-1:0]   w_px;
  logic [Y_W-1:0]   w_py;
  logic [2:0]       w_pc;
  logic             w_pen;

  always_comb begin
    w_free    = '0;
    w_free_ok = 1'b0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (!r_active[i]) begin
        w_free    = IDX_W'(i);
        w_free_ok = 1'b1;
      end
    end
  end

  assign w_act_ext  = AW'(r_active);
  assign w_hit_ok   = hit_valid && w_act_ext[hit_idx];
  assign w_fire     = fire || r_pend;
  assign w_spawn    = w_fire && w_free_ok &&
                      (r_cool == '0);
  assign w_accept   = w_pen && plot.plot_ready;
  assign w_cur_act  = r_active[r_idx];
  // A hit landing in the erase cycle still retires the slot.
  assign w_kill_now = r_kill[r_idx] ||
                      (hit_valid && hit_idx == r_idx);
  assign w_retire   = w_kill_now ||
                      (r_y[r_idx] < Y_W'(STEP));
  assign w_last     = (r_idx == IDX_W'(NUM_BULLETS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    w_pen    = 1'b0;
    w_px     = '0;
    w_py     = '0;
    w_pc     = 3'b000;
    unique case (r_state)
      S_IDLE: begin
        if (frame_tick)   w_nstate = S_ERASE;
        else if (w_spawn) w_nstate = S_SPAWN;
      end
      S_SPAWN: begin
        w_pen = 1'b1;
        w_px  = r_x[r_idx];
        w_py  = r_y[r_idx];
        w_pc  = 3'b111;
        if (plot.plot_ready) w_nstate = S_IDLE;
      end
      S_ERASE: begin
        if (w_cur_act) begin
          w_pen = 1'b1;
          w_px  = r_x[r_idx];
          w_py  = r_y[r_idx];
          if (plot.plot_ready)
            w_nstate = w_retire ? S_NEXT : S_DRAW;
        end else begin
          w_nstate = S_NEXT;
        end
      end
      S_DRAW: begin
        w_pen = 1'b1;
        w_px  = r_x[r_idx];
        w_py  = r_y[r_idx];
        w_pc  = 3'b111;
        if (plot.plot_ready) w_nstate = S_NEXT;
      end
      S_NEXT: begin
        w_nstate = w_last ? S_IDLE : S_ERASE;
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx    <= '0;
      r_active <= '0;
      r_kill   <= '0;
      r_pend   <= 1'b0;
      r_cool   <= '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        r_x[i] <= '0;
        r_y[i] <= Y_W'(START_Y);
      end
    end else begin
      if (fire)     r_pend <= 1'b1;
      if (w_hit_ok) r_kill[hit_idx] <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (frame_tick) begin
            r_idx <= '0;
          end else if (w_fire) begin
            r_pend <= 1'b0;
            if (w_spawn) begin
              r_idx            <= w_free;
              r_x[w_free]      <= xin;
              r_y[w_free]      <= Y_W'(START_Y);
              r_active[w_free] <= 1'b1;
              r_cool           <= CW'(COOLDOWN);
            end
          end
        end
        S_ERASE: begin
          if (w_cur_act && w_accept) begin
            if (w_retire) begin
              r_active[r_idx] <= 1'b0;
              r_kill[r_idx]   <= 1'b0;
            end else begin
              r_y[r_idx] <= r_y[r_idx] - Y_W'(STEP);
            end
          end
        end
        S_NEXT: begin
          if (w_last) begin
            if (r_cool != '0) r_cool <= r_cool - CW'(1);
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign plot.plot_x      = w_px;
  assign plot.plot_y      = w_py;
  assign plot.plot_colour = w_pc;
  assign plot.plot_en     = w_pen;

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_pack
    assign bullet_x[g*X_W +: X_W] = r_x[g];
    assign bullet_y[g*Y_W +: Y_W] = r_y[g];
  end

  assign active_mask = r_active;
  assign busy        = (r_state != S_IDLE);
  assign tick_missed = frame_tick && (r_state != S_IDLE);
endmodule

// File: tb/tb_bullet_pool.sv
// Randomised scoreboard bench for bullet_pool against a
// slot-level reference model of spawn/move/retire rules.
module tb_bullet_pool;
  localparam int N = 4;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } px_t;

  logic         clk = 0;
  logic         rst_n = 0;
  logic         fire = 0;
  logic [7:0]   xin = 0;
  logic         frame_tick = 0;
  logic         hit_valid = 0;
  logic [1:0]   hit_idx = 0;
  logic [N-1:0] active_mask;
  logic [N*8-1:0] bullet_x;
  logic [N*7-1:0] bullet_y;
  logic         busy;
  logic         tick_missed;

  bullet_pool_if #(.X_W(8), .Y_W(7)) pif ();

  bullet_pool dut (
    .clk         (clk),
    .reset       (rst_n),
    .fire        (fire),
    .xin         (xin),
    .frame_tick  (frame_tick),
    .hit_valid   (hit_valid),
    .hit_idx     (hit_idx),
    .plot        (pif),
    .active_mask (active_mask),
    .bullet_x    (bullet_x),
    .bullet_y    (bullet_y),
    .busy        (busy),
    .tick_missed (tick_missed)
  );

  always #5 clk = ~clk;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  rmode   = 2;
  px_t exp_q[$];

  int mx[N];
  int my[N];
  bit mact[N];
  bit mkill[N];
  int mcool;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = 0; my[i] = 105; mact[i] = 0; mkill[i] = 0;
    end
    mcool = 0;
  endtask

  task automatic m_fire(input int x);
    int s = -1;
    for (int i = N - 1; i >= 0; i--) if (!mact[i]) s = i;
    if (s >= 0 && mcool == 0) begin
      mact[s] = 1; mx[s] = x; my[s] = 105; mkill[s] = 0;
      mcool = 3;
      exp_q.push_back('{8'(x), 7'd105, 3'b111});
    end
  endtask

  task automatic m_tick();
    for (int i = 0; i < N; i++) begin
      if (mact[i]) begin
        exp_q.push_back('{8'(mx[i]), 7'(my[i]), 3'b000});
        if (mkill[i] || my[i] < 5) begin
          mact[i] = 0; mkill[i] = 0;
        end else begin
          my[i] -= 5;
          exp_q.push_back('{8'(mx[i]), 7'(my[i]), 3'b111});
        end
      end
    end
    if (mcool > 0) mcool--;
  endtask

  task automatic m_hit(input int idx);
    if (mact[idx]) mkill[idx] = 1;
  endtask

  task automatic chk_state();
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = mact[i];
    chk("mask", 32'(active_mask), 32'(m));
    for (int i = 0; i < N; i++) begin
      if (mact[i]) begin
        chk($sformatf("x%0d", i), 32'(bullet_x[i*8 +: 8]), 32'(mx[i]));
        chk($sformatf("y%0d", i), 32'(bullet_y[i*7 +: 7]), 32'(my[i]));
      end
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: busy=%0b queued=%0d", busy, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_fire(input logic [7:0] x);
    @(posedge clk); #1;
    fire = 1; xin = x;
    m_fire(int'(x));
    @(posedge clk); #1;
    fire = 0;
  endtask

  task automatic do_tick();
    @(posedge clk); #1;
    frame_tick = 1;
    m_tick();
    @(posedge clk); #1;
    frame_tick = 0;
  endtask

  task automatic do_hit(input int idx);
    @(posedge clk); #1;
    hit_valid = 1; hit_idx = 2'(idx);
    m_hit(idx);
    @(posedge clk); #1;
    hit_valid = 0;
  endtask

  initial begin
    plot_ready_init();
  end

  task automatic plot_ready_init();
    pif.plot_ready = 0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       pif.plot_ready = ($urandom_range(0, 3) != 0);
        1:       pif.plot_ready = 1'b0;
        default: pif.plot_ready = 1'b1;
      endcase
    end
  endtask

  logic       stall = 0;
  logic [7:0] hx;
  logic [6:0] hy;
  logic [2:0] hc;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 0;
    end else begin
      if (stall) begin
        chk("hold_en", 32'(pif.plot_en), 32'd1);
        chk("hold_pix",
            32'({pif.plot_x, pif.plot_y, pif.plot_colour}),
            32'({hx, hy, hc}));
      end
      if (pif.plot_en && pif.plot_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL pixel_unexpected: got %0d,%0d,%0b",
                   pif.plot_x, pif.plot_y, pif.plot_colour);
        end else begin
          px_t e;
          e = exp_q.pop_front();
          chk("pixel",
              32'({pif.plot_x, pif.plot_y, pif.plot_colour}),
              32'({e.x, e.y, e.c}));
        end
      end
      stall = pif.plot_en && !pif.plot_ready;
      hx = pif.plot_x;
      hy = pif.plot_y;
      hc = pif.plot_colour;
    end
  end

  initial begin
    int op;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_en", 32'(pif.plot_en), 32'd0);
    chk("rst_mask", 32'(active_mask), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bx", bullet_x, 32'd0);
    chk("rst_by", 32'(bullet_y), 32'({7'd105, 7'd105, 7'd105, 7'd105}));
    @(posedge clk); #1;
    rst_n = 1;

    do_fire(8'd40);
    @(negedge clk);
    chk("t1_en", 32'(pif.plot_en), 32'd1);
    chk("t1_mask", 32'(active_mask), 32'b0001);
    wait_idle();
    chk_state();
    do_fire(8'd90);
    wait_idle();
    chk_state();

    do_tick();
    wait_idle();
    chk("t2_y0", 32'(bullet_y[6:0]), 32'd100);
    chk_state();

    rmode = 0;
    repeat (22) begin
      do_tick();
      wait_idle();
      chk_state();
    end

    repeat (4) begin
      do_fire(8'($urandom_range(0, 159)));
      wait_idle();
      repeat (3) begin do_tick(); wait_idle(); end
    end
    chk_state();
    do_fire(8'd11);
    wait_idle();
    chk_state();
    do_hit(2);
    do_tick();
    wait_idle();
    chk("t4_mask", 32'(active_mask), 32'b1011);
    chk_state();

    rmode = 2;
    @(posedge clk);
    @(posedge clk); #1;
    frame_tick = 1;
    m_hit(0);
    m_tick();
    @(posedge clk); #1;
    frame_tick = 0;
    hit_valid = 1; hit_idx = 0;
    @(posedge clk); #1;
    hit_valid = 0;
    wait_idle();
    chk_state();

    do_fire(8'd150);
    wait_idle();
    rmode = 1;
    @(posedge clk);
    do_tick();
    repeat (10) @(negedge clk);
    chk("t5_stall_en", 32'(pif.plot_en), 32'd1);
    @(posedge clk); #1;
    frame_tick = 1;
    fire = 1; xin = 8'd123;
    m_fire(123);
    @(negedge clk);
    chk("t5_missed", 32'(tick_missed), 32'd1);
    @(posedge clk); #1;
    frame_tick = 0;
    fire = 0;
    @(negedge clk);
    chk("t5_missed_end", 32'(tick_missed), 32'd0);
    rmode = 0;
    wait_idle();
    chk_state();

    repeat (60) begin
      op = $urandom_range(0, 9);
      if (op < 3) do_fire(8'($urandom_range(0, 255)));
      else if (op < 8) do_tick();
      else do_hit($urandom_range(0, N - 1));
      wait_idle();
      chk_state();
    end

    if (!mact[0]) begin
      repeat (3) begin do_tick(); wait_idle(); end
      do_fire(8'd66);
      wait_idle();
    end
    rmode = 1;
    @(posedge clk);
    do_tick();
    repeat (3) @(negedge clk);
    chk("t6_en", 32'(pif.plot_en), 32'd1);
    rst_n = 0;
    #1;
    chk("t6_en_rst", 32'(pif.plot_en), 32'd0);
    chk("t6_mask_rst", 32'(active_mask), 32'd0);
    chk("t6_busy_rst", 32'(busy), 32'd0);
    chk("t6_by_rst", 32'(bullet_y),
        32'({7'd105, 7'd105, 7'd105, 7'd105}));
    exp_q.delete();
    m_reset();
    rmode = 2;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    do_fire(8'd77);
    wait_idle();
    chk("t6_mask", 32'(active_mask), 32'b0001);
    chk_state();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: tests=%0d", n_tests);
    $fatal(1);
  end
endmodule
